sixteen_bit_serial_subtractor: RTL and testbench
================================================

// Module: sixteen_bit_serial_subtractor
// PURPOSE
//  Multi-cycle 16-bit subtractor; the inverse arithmetic unit of the 16-bit adder.
//  Computes {borrow, difference} = {1'b0,minuend} - {1'b0,subtrahend}, one 4-bit
//  digit per clock, least-significant digit first.
//  Sits in the ALU datapath beside the adder; the control unit drives it through
//  a start/busy/done handshake.
// PARAMETERS
//  DATA_W   16  operand/result width; fixed, must equal DIGIT_W*NUM_DIG
//  DIGIT_W  4   bits processed per clock
//  NUM_DIG  4   digits per operation (= cycles in RUN)
// PORTS
//  clk                    in   1   rising-edge clock
//  reset_n                in   1   asynchronous active-low reset
//  start                  in   1   request; sampled only while busy=0
//  sixteenbitminuend      in   16  operand A; sampled with start
//  sixteenbitsubtrahend   in   16  operand B; sampled with start
//  sixteenbitdifference   out  16  registered A-B, mod 2^16
//  sixteenbitborrow_out   out  1   registered borrow; 1 iff A<B unsigned
//  busy                   out  1   high during RUN
//  done                   out  1   one-cycle pulse; result valid
//  zero_flag              out  1   only with SUB_FLAGS_EN
//  overflow_flag          out  1   only with SUB_FLAGS_EN
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, digit counter=0, borrow chain=0;
//    all outputs 0 (difference, borrow_out, busy, done, flags).
//  - FSM: IDLE -> RUN on start=1 (edge E0). RUN -> RUN while cnt<3.
//    RUN(cnt=3) -> DONE. DONE -> IDLE after one cycle, or -> RUN if start=1.
//  - E0: latch A and B into shift registers; set cnt=0 and borrow_in=0;
//    busy=1 after E0.
//  - Edges E1..E4: digit k=cnt is computed by nibble_subtractor:
//    {b_out,d} = A[k] - B[k] - b_in. d goes into an internal accumulator;
//    b_out is registered as the next b_in.
//  - E4: accumulator and final borrow are copied to the output registers;
//    done=1 and busy=0 for exactly one cycle. Latency is 4 clocks, start to done.
//  - Outputs hold the previous result until the next done. Nothing partial is
//    ever visible.
//  - start while busy=1 is ignored. Operand changes after E0 have no effect.
//  - start during DONE is accepted: back-to-back operations, one result every 5 clocks.
//  - Reset asserted mid-operation aborts it immediately: no done, outputs 0.
//  - Wrap-around: 0x0000-0x0001 gives 0xFFFF, borrow=1. Equal operands give 0x0000, borrow=0.
// CONFIGURATION
//  SUB_FLAGS_EN defined: zero_flag = (difference==0) and
//    overflow_flag = (A[15]!=B[15]) && (D[15]!=A[15]) (signed overflow).
//    Both are registered at E4 alongside the result; reset value 0.
//  SUB_FLAGS_EN undefined: both ports and their logic are absent. The rest is identical.
// STRUCTURE
//  Shared package sub_pkg: DATA_W, DIGIT_W, NUM_DIG constants; state encoding
//    IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
//  Sub-module nibble_subtractor: combinational, 4-bit a, b, b_in -> d, b_out.
//  Top level holds the FSM, the digit counter, the operand shifters and the output registers.
// TESTING
//  1 A=0x1234, B=0x0034, start pulse -> done exactly 4 clks later; D=0x1200, borrow=0.
//  2 A=0x0000, B=0x0001 -> D=0xFFFF, borrow=1. With SUB_FLAGS_EN: zero=0, overflow=0.
//  3 A=0x8000, B=0x0001 -> D=0x7FFF, borrow=0, overflow=1.
//    Then A=B=0x5A5A -> D=0x0000, zero=1.
//  4 start re-pulsed with new operands at E2 -> ignored; first result delivered
//    unchanged, one done pulse only.
//  5 reset_n low at E2 -> busy, done and D go to 0 at once; no done follows.
//    The next op after release is correct.
//  6 1500 random back-to-back ops (start held high) -> every result matches
//    {1'b0,A}-{1'b0,B}; error count 0.

Source files
------------

// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_pkg
//  Description : Shared constants and FSM state encoding for the 16-bit
//                digit-serial subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
package sub_pkg;

    localparam int DATA_W  = 16;
    localparam int DIGIT_W = 4;
    localparam int NUM_DIG = 4;
    localparam int CNT_W   = 2;

    // 2'd3 is unused and decodes back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage
`default_nettype wire

// File: rtl/sixteen_bit_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : sixteen_bit_serial_subtractor_if
//  Description : Start/busy/done handshake and operand/result bus of the
//                serial subtractor. Flag signals exist only when SUB_FLAGS_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface sixteen_bit_serial_subtractor_if;

    logic        start;
    logic [15:0] sixteenbitminuend;
    logic [15:0] sixteenbitsubtrahend;
    logic [15:0] sixteenbitdifference;
    logic        sixteenbitborrow_out;
    logic        busy;
    logic        done;
`ifdef SUB_FLAGS_EN
    logic        zero_flag;
    logic        overflow_flag;

    modport master (
        output start, sixteenbitminuend, sixteenbitsubtrahend,
        input  sixteenbitdifference, sixteenbitborrow_out, busy, done,
        input  zero_flag, overflow_flag
    );

    modport slave (
        input  start, sixteenbitminuend, sixteenbitsubtrahend,
        output sixteenbitdifference, sixteenbitborrow_out, busy, done,
        output zero_flag, overflow_flag
    );
`else
    modport master (
        output start, sixteenbitminuend, sixteenbitsubtrahend,
        input  sixteenbitdifference, sixteenbitborrow_out, busy, done
    );

    modport slave (
        input  start, sixteenbitminuend, sixteenbitsubtrahend,
        output sixteenbitdifference, sixteenbitborrow_out, busy, done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/nibble_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_subtractor
//  Description : Combinational one-digit subtractor with borrow in/out:
//                {b_out, d} = a - b - b_in.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_subtractor #(
    parameter int DIGIT_W = 4
) (
    input  wire logic [DIGIT_W-1:0] a,
    input  wire logic [DIGIT_W-1:0] b,
    input  wire logic               b_in,
    output logic      [DIGIT_W-1:0] d,
    output logic                    b_out
);

    logic [DIGIT_W:0] w_diff;

    // Extra MSB of the widened difference is the borrow out
    always_comb begin
        w_diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, b_in};
        d      = w_diff[DIGIT_W-1:0];
        b_out  = w_diff[DIGIT_W];
    end

endmodule
`default_nettype wire

// File: rtl/sixteen_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : sixteen_bit_serial_subtractor
//  Description : 16-bit subtractor processing one 4-bit digit per clock,
//                LS digit first. Result and borrow are published together
//                with a one-cycle done pulse four clocks after start.
//                Optional feature macro: SUB_FLAGS_EN (zero/overflow flags).
//  Revision    : 1.0  initial release
// ============================================================================
module sixteen_bit_serial_subtractor
    import sub_pkg::*;
(
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    sixteen_bit_serial_subtractor_if.slave  bus
);

    sub_state_t                 r_state;
    sub_state_t                 w_state_next;
    logic [CNT_W-1:0]           r_cnt;
    logic [DATA_W-1:0]          r_a;
    logic [DATA_W-1:0]          r_b;
    logic [DATA_W-DIGIT_W-1:0]  r_acc;
    logic                       r_bin;
    logic [DATA_W-1:0]          r_diff;
    logic                       r_borrow;
    logic [DIGIT_W-1:0]         w_d;
    logic                       w_bout;
    logic                       w_load;
    logic                       w_step;
    logic                       w_last;
    logic [DATA_W-1:0]          w_result;

    assign w_last   = (r_cnt == CNT_W'(NUM_DIG - 1));
    assign w_result = {w_d, r_acc};

    nibble_subtractor #(
        .DIGIT_W (DIGIT_W)
    ) u_nibble (
        .a     (r_a[DIGIT_W-1:0]),
        .b     (r_b[DIGIT_W-1:0]),
        .b_in  (r_bin),
        .d     (w_d),
        .b_out (w_bout)
    );

    // Next-state decode; start is honoured only when not busy
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Operand shifters, digit counter, borrow chain and partial accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_bin <= 1'b0;
        end else if (w_load) begin
            r_a   <= bus.sixteenbitminuend;
            r_b   <= bus.sixteenbitsubtrahend;
            r_cnt <= '0;
            r_bin <= 1'b0;
        end else if (w_step) begin
            r_a   <= r_a >> DIGIT_W;
            r_b   <= r_b >> DIGIT_W;
            r_acc <= {w_d, r_acc[DATA_W-DIGIT_W-1:DIGIT_W]};
            r_bin <= w_bout;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers update only on the final digit, so partials never leak
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_step && w_last) begin
            r_diff   <= w_result;
            r_borrow <= w_bout;
        end
    end

`ifdef SUB_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    // Flags: on the last digit the shifters still hold the operand MS digits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_step && w_last) begin
            r_zero <= (w_result == '0);
            r_ovf  <= (r_a[DIGIT_W-1] != r_b[DIGIT_W-1]) &&
                      (w_d[DIGIT_W-1] != r_a[DIGIT_W-1]);
        end
    end

    assign bus.zero_flag     = r_zero;
    assign bus.overflow_flag = r_ovf;
`endif

    assign bus.sixteenbitdifference = r_diff;
    assign bus.sixteenbitborrow_out = r_borrow;
    assign bus.busy                 = (r_state == RUN);
    assign bus.done                 = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sixteen_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sixteen_bit_serial_subtractor
//  Description : Directed self-checking bench for the serial subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sixteen_bit_serial_subtractor;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sixteen_bit_serial_subtractor_if sif ();

    sixteen_bit_serial_subtractor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; returns number of clock edges waited
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (sif.done !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Start one operation from idle, check latency, result and done pulse width
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input logic exp_bo);
        int cyc;
        @(negedge clk);
        sif.sixteenbitminuend    = a;
        sif.sixteenbitsubtrahend = b;
        sif.start                = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
        chk({tag, "_busy"}, {31'd0, sif.busy}, 32'd1);
        wait_done(cyc);
        chk({tag, "_latency"}, cyc, 32'd4);
        chk({tag, "_diff"}, {16'd0, sif.sixteenbitdifference}, {16'd0, exp_d});
        chk({tag, "_borrow"}, {31'd0, sif.sixteenbitborrow_out}, {31'd0, exp_bo});
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, sif.done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        logic [15:0] ca, cb, na, nb;
        logic [16:0] ref_v;

        sif.start                = 1'b0;
        sif.sixteenbitminuend    = 16'h0000;
        sif.sixteenbitsubtrahend = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_diff", {16'd0, sif.sixteenbitdifference}, 32'd0);
        chk("rst_borrow", {31'd0, sif.sixteenbitborrow_out}, 32'd0);
        chk("rst_busy", {31'd0, sif.busy}, 32'd0);
        chk("rst_done", {31'd0, sif.done}, 32'd0);
`ifdef SUB_FLAGS_EN
        chk("rst_zero", {31'd0, sif.zero_flag}, 32'd0);
        chk("rst_ovf", {31'd0, sif.overflow_flag}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: basic
        run_op("t1", 16'h1234, 16'h0034, 16'h1200, 1'b0);
        chk("t1_hold_diff", {16'd0, sif.sixteenbitdifference}, 32'h1200);

        // 2: wrap-around
        run_op("t2", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
`ifdef SUB_FLAGS_EN
        chk("t2_zero", {31'd0, sif.zero_flag}, 32'd0);
        chk("t2_ovf", {31'd0, sif.overflow_flag}, 32'd0);
`endif

        // 3: signed overflow, then equal operands
        run_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 1'b0);
`ifdef SUB_FLAGS_EN
        chk("t3a_ovf", {31'd0, sif.overflow_flag}, 32'd1);
        chk("t3a_zero", {31'd0, sif.zero_flag}, 32'd0);
`endif
        run_op("t3b", 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0);
`ifdef SUB_FLAGS_EN
        chk("t3b_zero", {31'd0, sif.zero_flag}, 32'd1);
        chk("t3b_ovf", {31'd0, sif.overflow_flag}, 32'd0);
`endif
        // Borrow propagating through every digit
        run_op("t3c", 16'h1000, 16'h0001, 16'h0FFF, 1'b0);

        // 4: start re-pulse at E2 with new operands is ignored
        @(negedge clk);
        sif.sixteenbitminuend    = 16'h9876;
        sif.sixteenbitsubtrahend = 16'h1234;
        sif.start                = 1'b1;
        @(posedge clk); #1;                 // E0
        sif.start = 1'b0;
        @(posedge clk);                     // E1
        @(negedge clk);
        sif.sixteenbitminuend    = 16'hFFFF;
        sif.sixteenbitsubtrahend = 16'h0001;
        sif.start                = 1'b1;
        @(posedge clk); #1;                 // E2
        sif.start = 1'b0;
        dones = 0;
        cyc   = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (sif.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    cyc = i;
                    chk("t4_diff", {16'd0, sif.sixteenbitdifference}, 32'h8642);
                    chk("t4_borrow", {31'd0, sif.sixteenbitborrow_out}, 32'd0);
                end
            end
        end
        chk("t4_done_count", dones, 32'd1);
        chk("t4_done_edge", cyc, 32'd1);     // E4 is the 2nd edge after E2

        // 5: reset at E2 aborts immediately
        @(negedge clk);
        sif.sixteenbitminuend    = 16'h4444;
        sif.sixteenbitsubtrahend = 16'h1111;
        sif.start                = 1'b1;
        @(posedge clk); #1;                 // E0
        sif.start = 1'b0;
        @(posedge clk);                     // E1
        @(posedge clk); #1;                 // E2
        reset_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, sif.busy}, 32'd0);
        chk("t5_done", {31'd0, sif.done}, 32'd0);
        chk("t5_diff", {16'd0, sif.sixteenbitdifference}, 32'd0);
        chk("t5_borrow", {31'd0, sif.sixteenbitborrow_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (sif.done === 1'b1 || sif.busy === 1'b1) dones++;
        end
        chk("t5_no_done", dones, 32'd0);
        run_op("t5_after", 16'h4444, 16'h1111, 16'h3333, 1'b0);

        // 6: back-to-back random operations, start held high
        ca = 16'($urandom);
        cb = 16'($urandom);
        @(negedge clk);
        sif.sixteenbitminuend    = ca;
        sif.sixteenbitsubtrahend = cb;
        sif.start                = 1'b1;
        @(posedge clk); #1;                 // accepted
        for (int i = 0; i < 1500; i++) begin
            na = 16'($urandom);
            nb = 16'($urandom);
            if (i == 0) begin
                na = 16'h0000; nb = 16'hFFFF;
            end
            sif.sixteenbitminuend    = na;  // no effect on the running op
            sif.sixteenbitsubtrahend = nb;
            wait_done(cyc);
            ref_v = {1'b0, ca} - {1'b0, cb};
            chk("t6_result", {cyc[14:0], sif.sixteenbitborrow_out, sif.sixteenbitdifference},
                {15'd4, ref_v});
            if (i == 1499) sif.start = 1'b0;
            ca = na;
            cb = nb;
            @(posedge clk); #1;             // DONE edge: next op accepted
        end
        repeat (8) @(posedge clk);
        #1;
        chk("t6_idle", {30'd0, sif.busy, sif.done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
